// File: rtl/i2c_target_rx.sv
// I2C target write receiver: START/STOP detect, 7-bit address match, FWFT byte FIFO.
// Define I2C_TARGET_STRETCH_EN to hold scl low on a full FIFO instead of NACKing.
module i2c_target_rx #(
  parameter logic [6:0]  ADDR  = 7'h3C,
  parameter int unsigned DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire        sda,
  inout  wire        scl,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StData,
    StDataAck,
    StIgnore
  } state_e;

  logic        sda_s1_q, sda_s2_q, sda_p_q;
  logic        scl_s1_q, scl_s2_q, scl_p_q;
  logic        start_ev, stop_ev, scl_rise, scl_fall;
  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        push, pop, full, empty, sda_oe;
`ifdef I2C_TARGET_STRETCH_EN
  logic        stretch_q, stretch_d;
`endif

  assign start_ev = scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
  assign stop_ev  = scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;
  assign scl_rise = scl_s2_q & ~scl_p_q;
  assign scl_fall = ~scl_s2_q & scl_p_q;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = ~empty & rx_ready;

  // State register, synchronisers and FIFO pointers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sda_s1_q  <= 1'b1;
      sda_s2_q  <= 1'b1;
      sda_p_q   <= 1'b1;
      scl_s1_q  <= 1'b1;
      scl_s2_q  <= 1'b1;
      scl_p_q   <= 1'b1;
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
`ifdef I2C_TARGET_STRETCH_EN
      stretch_q <= 1'b0;
`endif
    end else begin
      sda_s1_q  <= sda;
      sda_s2_q  <= sda_s1_q;
      sda_p_q   <= sda_s2_q;
      scl_s1_q  <= scl;
      scl_s2_q  <= scl_s1_q;
      scl_p_q   <= scl_s2_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
`ifdef I2C_TARGET_STRETCH_EN
      stretch_q <= stretch_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= shift_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    push      = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
    stretch_d = stretch_q;
`endif

    if (scl_rise && (state_q == StAddr || state_q == StData) && bit_cnt_q < 4'd8) begin
      shift_d   = {shift_q[6:0], sda_s2_q};
      bit_cnt_d = bit_cnt_q + 4'd1;
    end

    case (state_q)
      StAddr: begin
        if (scl_fall && bit_cnt_q == 4'd8) begin
          bit_cnt_d = '0;
          if (shift_q == {ADDR, 1'b0}) begin
            state_d = StAddrAck;
            busy_d  = 1'b1;
          end else begin
            state_d = StIgnore;
          end
        end
      end
      StAddrAck: begin
        if (scl_fall) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
`ifdef I2C_TARGET_STRETCH_EN
        if (stretch_q) begin
          // scl stays held one more cycle so ACK is on sda before scl is let go.
          if (!full) begin
            push    = 1'b1;
            ack_d   = 1'b1;
            state_d = StDataAck;
          end
        end else
`endif
        if (scl_fall && bit_cnt_q == 4'd8) begin
          if (!full) begin
            push    = 1'b1;
            ack_d   = 1'b1;
            state_d = StDataAck;
          end else begin
`ifdef I2C_TARGET_STRETCH_EN
            stretch_d = 1'b1;
`else
            ovf_d   = 1'b1;
            ack_d   = 1'b0;
            state_d = StDataAck;
`endif
          end
        end
      end
      StDataAck: begin
`ifdef I2C_TARGET_STRETCH_EN
        if (stretch_q) begin
          stretch_d = 1'b0;
        end else
`endif
        if (scl_fall) begin
          state_d   = StData;
          ack_d     = 1'b0;
          bit_cnt_d = '0;
        end
      end
      default: ;
    endcase

    if (start_ev) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      busy_d    = 1'b0;
      ack_d     = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
      stretch_d = 1'b0;
`endif
    end
    if (stop_ev) begin
      state_d = StIdle;
      done_d  = busy_q;
      busy_d  = 1'b0;
      ack_d   = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
      stretch_d = 1'b0;
`endif
    end

    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
  end

  // Outputs.
  always_comb begin
    sda_oe     = (state_q == StAddrAck) || (state_q == StDataAck && ack_q);
    rx_valid   = ~empty;
    rx_data    = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
    busy       = busy_q;
    frame_done = done_q;
    overflow   = ovf_q;
  end

  assign sda = sda_oe ? 1'b0 : 1'bz;
`ifdef I2C_TARGET_STRETCH_EN
  assign scl = stretch_q ? 1'b0 : 1'bz;
`else
  assign scl = 1'bz;
`endif

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bus master model, queue scoreboard and free-running monitor.
`timescale 1ns/1ps
module tb_i2c_target_rx;

  localparam logic [6:0]  ADDR  = 7'h3C;
  localparam int unsigned DEPTH = 8;
  localparam int          H     = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx_ready = 1'b0;
  logic       m_sda_oe = 1'b0;
  logic       m_scl_oe = 1'b0;
  wire        sda_w, scl_w;
  logic [7:0] rx_data;
  logic       rx_valid, busy, frame_done, overflow;

  pullup (sda_w);
  pullup (scl_w);
  assign sda_w = m_sda_oe ? 1'b0 : 1'bz;
  assign scl_w = m_scl_oe ? 1'b0 : 1'bz;

  int         checks = 0, errors = 0;
  int         done_cnt = 0, exp_done = 0, max_stretch = 0;
  bit         exp_ovf = 1'b0, addressed = 1'b0;
  logic [7:0] exp_q [$];
  logic [7:0] hello [5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};

  always #5 clock = ~clock;

  i2c_target_rx #(.ADDR(ADDR), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .sda        (sda_w),
    .scl        (scl_w),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: pops the scoreboard on every accepted byte.
  always @(negedge clock) begin
    if (reset && frame_done === 1'b1) done_cnt++;
    if (reset && rx_valid === 1'b1 && rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_spurious: got byte %02h, expected no byte", rx_data);
      end else begin
        chk("rx_data", rx_data, exp_q.pop_front());
      end
    end
  end

  task automatic scl_release();
    int w = 0;
    m_scl_oe = 1'b0;
    #1;
    while (scl_w !== 1'b1 && w < 5000) begin
      clk(1);
      w++;
    end
    if (w >= 5000) begin
      checks++;
      errors++;
      $display("FAIL scl_timeout: scl held low for %0d cycles, expected release", w);
    end
    if (w > max_stretch) max_stretch = w;
  endtask

  task automatic m_bit(input bit v, output bit s);
    clk(2);
    m_sda_oe = ~v;
    clk(H);
    scl_release();
    clk(H);
    s = sda_w;
    m_scl_oe = 1'b1;
  endtask

  task automatic m_start();
    clk(2);
    m_sda_oe = 1'b0;
    clk(H);
    scl_release();
    clk(H);
    m_sda_oe = 1'b1;
    clk(H);
    m_scl_oe = 1'b1;
  endtask

  task automatic m_stop();
    clk(2);
    m_sda_oe = 1'b1;
    clk(H);
    scl_release();
    clk(H);
    m_sda_oe = 1'b0;
    clk(H);
  endtask

  task automatic mid_reset();
    reset = 1'b0;
    exp_q.delete();
    addressed = 1'b0;
    exp_ovf = 1'b0;
    clk(1);
    chk("rst_sda_released", sda_w, 1'b1);
    clk(1);
    reset = 1'b1;
    clk(1);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_data", rx_data, 8'h00);
  endtask

  task automatic m_byte(input logic [7:0] b, input int rst_bit, output bit ack);
    bit s;
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) mid_reset();
      m_bit(b[7-i], s);
    end
    m_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic t_start();
    m_start();
    addressed = 1'b0;
  endtask

  task automatic t_addr(input logic [6:0] a, input bit rw);
    bit ack, exp;
    m_byte({a, rw}, -1, ack);
    exp = (a == ADDR) && !rw;
    chk("addr_ack", ack, exp);
    chk("busy_after_addr", busy, exp);
    addressed = exp;
  endtask

  task automatic t_data(input logic [7:0] b, input int rst_bit);
    bit ack, room;
`ifdef I2C_TARGET_STRETCH_EN
    room = 1'b1;
`else
    room = exp_q.size() < DEPTH;
`endif
    if (addressed && room) exp_q.push_back(b);
    m_byte(b, rst_bit, ack);
    chk("data_ack", ack, addressed && room);
    if (addressed && !room) exp_ovf = 1'b1;
  endtask

  task automatic t_stop();
    m_stop();
    if (addressed) exp_done++;
    addressed = 1'b0;
  endtask

  task automatic end_check();
    clk(10);
    chk("frame_done_count", done_cnt, exp_done);
    chk("overflow", overflow, exp_ovf);
    chk("busy_idle", busy, 1'b0);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    clk(3 * DEPTH + 10);
    chk("drained", exp_q.size(), 0);
    chk("valid_after_drain", rx_valid, 1'b0);
  endtask

  initial begin
    clk(5);
    chk("reset_valid", rx_valid, 1'b0);
    chk("reset_data", rx_data, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", frame_done, 1'b0);
    chk("reset_overflow", overflow, 1'b0);
    chk("reset_sda", sda_w, 1'b1);
    chk("reset_scl", scl_w, 1'b1);
    reset = 1'b1;
    clk(5);

    // "hello" write with consumer always ready.
    rx_ready = 1'b1;
    t_start();
    t_addr(ADDR, 1'b0);
    foreach (hello[i]) t_data(hello[i], -1);
    t_stop();
    end_check();
    drain();

    // Wrong address, then a read request.
    t_start();
    t_addr(7'h3D, 1'b0);
    t_data(8'hA5, -1);
    t_data(8'h5A, -1);
    t_stop();
    end_check();
    chk("nack_no_valid", rx_valid, 1'b0);
    t_start();
    t_addr(ADDR, 1'b1);
    t_stop();
    end_check();
    chk("read_no_valid", rx_valid, 1'b0);

    // Ten bytes into a stalled consumer.
    rx_ready = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
    fork
      begin
        clk(2500);
        rx_ready = 1'b1;
      end
    join_none
`endif
    t_start();
    t_addr(ADDR, 1'b0);
    for (int i = 0; i < 10; i++) t_data(8'(i), -1);
    t_stop();
    end_check();
    drain();

    // Repeated START mid-frame.
    t_start();
    t_addr(ADDR, 1'b0);
    t_data(8'h11, -1);
    t_data(8'h22, -1);
    t_start();
    t_addr(ADDR, 1'b0);
    t_data(8'h33, -1);
    t_stop();
    end_check();
    drain();

    // Reset during the 4th bit of the first data byte, then a clean frame.
    t_start();
    t_addr(ADDR, 1'b0);
    t_data(hello[0], 3);
    for (int i = 1; i < 5; i++) t_data(hello[i], -1);
    t_stop();
    end_check();
    t_start();
    t_addr(ADDR, 1'b0);
    foreach (hello[i]) t_data(hello[i], -1);
    t_stop();
    end_check();
    drain();

    // Randomised frames.
    for (int f = 0; f < 8; f++) begin
      logic [6:0] a;
      bit         rw;
      int         n, sel;
      sel = int'($urandom % 4);
      a = (sel < 2) ? ADDR : (sel == 2) ? 7'h3D : 7'($urandom);
      rw = ($urandom % 4) == 0;
      rx_ready = 1'($urandom);
      n = 1 + int'($urandom % 10);
`ifdef I2C_TARGET_STRETCH_EN
      if (!rx_ready && n > 8) n = 8;
`endif
      t_start();
      t_addr(a, rw);
      if (addressed || (a != ADDR) || !rw) begin
        for (int i = 0; i < n; i++) t_data(8'($urandom), -1);
      end
      t_stop();
      end_check();
      drain();
    end

`ifdef I2C_TARGET_STRETCH_EN
    chk("scl_stretched", max_stretch > 100, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
